milano_prefetch_buffer: RTL and testbench

- Parametrised instruction-fetch front end for the milano core; next generation of the single-beat fetch path.
- Sits between the instruction memory bus (req/gnt/rvalid handshake, same style as the core's data interface) and the ID stage.
- Keeps up to MAX_OUTSTANDING fetches in flight and buffers up to DEPTH fetched instructions with their addresses.
- Handles jump flush, discards stale responses, and supports ID back-pressure via valid/ready.

---
 rtl/milano_prefetch_buffer_if.sv | 30 +++
 rtl/milano_prefetch_buffer.sv | 162 ++++++++++++++++
 tb/tb_milano_prefetch_buffer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/milano_prefetch_buffer_if.sv
// Instruction-memory bus and ID-side output bus of the milano prefetch buffer.
// The master modport is the prefetch buffer; the slave modport is memory plus ID.
interface milano_prefetch_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instr_req_o;
  logic [ADDR_W-1:0] instr_addr_o;
  logic              instr_gnt_i;
  logic              instr_rvalid_i;
  logic [DATA_W-1:0] instr_rdata_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_rdata_o;
  logic [ADDR_W-1:0] out_addr_o;

  modport master (
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output out_valid_o, out_rdata_o, out_addr_o,
    input  out_ready_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  out_valid_o, out_rdata_o, out_addr_o,
    output out_ready_i
  );
endinterface

// File: rtl/milano_prefetch_buffer.sv
// Instruction prefetch buffer: keeps up to MAX_OUTSTANDING fetches in flight,
// buffers DEPTH {addr, instr} entries for ID, and discards responses made stale by a jump.
module milano_prefetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] boot_addr_i,
  input  logic              fetch_en_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  milano_prefetch_buffer_if.master bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [OW-1:0] MAX_OS  = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);
  localparam logic [QW-1:0] AQ_LAST = QW'(MAX_OUTSTANDING - 1);

  localparam logic [0:0] S_BOOT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [OW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]     aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_rdata_q, out_rdata_d;

  logic [ADDR_W-1:0] aq_mem    [MAX_OUTSTANDING];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];

  logic              run, flush_run, req, accept, rvalid_live, push, pop;
  logic [CW:0]       live;
  logic [ADDR_W-1:0] boot_aligned, flush_aligned, aq_head;

  function automatic logic [QW-1:0] aq_next(input logic [QW-1:0] p);
    return (p == AQ_LAST) ? '0 : p + QW'(1);
  endfunction

  assign boot_aligned  = boot_addr_i & ~ADDR_W'(3);
  assign flush_aligned = flush_addr_i & ~ADDR_W'(3);
  assign aq_head       = aq_mem[aq_rd_q];

  assign run       = (state_q == S_RUN);
  assign flush_run = run && flush_i;
  // Responses still owed to the FIFO: buffered entries plus live (non-discarded) fetches.
  assign live      = {1'b0, fifo_cnt_q} + (CW + 1)'(outst_q) - (CW + 1)'(discard_q);
  assign req       = run && fetch_en_i && !flush_i && (outst_q < MAX_OS) && (live < DEPTH_L);
  assign accept    = req && bus.instr_gnt_i;
  // A response with nothing in flight is a leftover from before reset and is ignored.
  assign rvalid_live = bus.instr_rvalid_i && (outst_q != '0);
  assign push      = rvalid_live && (discard_q == '0) && !flush_run;
  assign pop       = (fifo_cnt_q != '0) && bus.out_ready_i && !flush_run;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = S_RUN;
    pc_d        = pc_q;
    discard_d   = discard_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_addr_d  = out_addr_q;
    out_rdata_d = out_rdata_q;

    if (!run)          pc_d = boot_aligned;
    else if (flush_i)  pc_d = flush_aligned;
    else if (accept)   pc_d = pc_q + ADDR_W'(4);

    outst_d = outst_q + OW'(accept) - OW'(rvalid_live);
    aq_wr_d = accept      ? aq_next(aq_wr_q) : aq_wr_q;
    aq_rd_d = rvalid_live ? aq_next(aq_rd_q) : aq_rd_q;

    // Everything still in flight after a jump belongs to the old path.
    if (flush_run)                          discard_d = outst_d;
    else if (rvalid_live && discard_q != '0) discard_d = discard_q - OW'(1);

    if (flush_run) begin
      fifo_cnt_d = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end

    // Registered head view; it only moves when an entry remains, so empty holds the last value.
    if (fifo_cnt_d != '0) begin
      if (push && rd_ptr_d == wr_ptr_q) begin
        out_addr_d  = aq_head;
        out_rdata_d = bus.instr_rdata_i;
      end else begin
        out_addr_d  = fifo_addr[rd_ptr_d];
        out_rdata_d = fifo_data[rd_ptr_d];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_BOOT;
      pc_q        <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      aq_wr_q     <= '0;
      aq_rd_q     <= '0;
      out_addr_q  <= '0;
      out_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      aq_wr_q     <= aq_wr_d;
      aq_rd_q     <= aq_rd_d;
      out_addr_q  <= out_addr_d;
      out_rdata_q <= out_rdata_d;
    end
  end

  // NOTE: storage arrays are not reset; the counters and pointers alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= aq_head;
      fifo_data[wr_ptr_q] <= bus.instr_rdata_i;
    end
    if (accept) aq_mem[aq_wr_q] <= pc_q;
  end

  assign bus.instr_req_o  = req;
  assign bus.instr_addr_o = pc_q;
  assign bus.out_valid_o  = (fifo_cnt_q != '0);
  assign bus.out_addr_o   = out_addr_q;
  assign bus.out_rdata_o  = out_rdata_q;

  a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (fifo_cnt_q != DEPTH_C));

  a_no_orphan_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.instr_rvalid_i && outst_q == '0) |-> !push);

endmodule

// File: tb/tb_milano_prefetch_buffer.sv
// Randomized scoreboard bench for milano_prefetch_buffer: a memory model returns
// in-order responses with random latency; ID output is checked against the sequential fetch stream.
module tb_milano_prefetch_buffer;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [AW-1:0] boot_addr_i;
  logic          fetch_en_i;
  logic          flush_i;
  logic [AW-1:0] flush_addr_i;

  milano_prefetch_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  milano_prefetch_buffer #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .boot_addr_i  (boot_addr_i),
    .fetch_en_i   (fetch_en_i),
    .flush_i      (flush_i),
    .flush_addr_i (flush_addr_i),
    .bus          (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rsp_t;

  int n_cmp = 0;
  int n_err = 0;

  rsp_t          mem_q[$];    // memory side: granted, not yet returned (stale included)
  logic [AW-1:0] exp_q[$];    // fetch addresses granted since the last jump, not yet consumed by ID
  logic [AW-1:0] popped_q[$]; // addresses consumed by ID since the last jump

  int gnt_pct, ready_pct, flush_pct, fe_pct, dmin, dmax;
  logic          force_flush;
  logic [AW-1:0] force_addr;
  logic [AW-1:0] model_pc;
  int step_n = 0;
  int grants = 0;
  int first_gnt_step = -1;
  int first_valid_step = -1;
  logic          s_req, s_rvalid, s_valid;
  logic [AW-1:0] s_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (step %0d)", name, act, exp, step_n);
    end
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic logic [AW-1:0] pv(input int i);
    if (i < popped_q.size()) return popped_q[i];
    return 'x;
  endfunction

  // One cycle: drive inputs after the falling edge, then sample and update the reference model.
  task automatic step();
    bit   fl;
    bit   exp_req;
    rsp_t r;
    @(negedge clk_i);
    step_n++;
    fl             = force_flush || ($urandom_range(0, 99) < flush_pct);
    flush_i        = fl;
    flush_addr_i   = force_flush ? force_addr : $urandom;
    force_flush    = 1'b0;
    fetch_en_i     = ($urandom_range(0, 99) < fe_pct);
    bus.instr_gnt_i = ($urandom_range(0, 99) < gnt_pct);
    bus.out_ready_i = ($urandom_range(0, 99) < ready_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= step_n) begin
      bus.instr_rvalid_i = 1'b1;
      bus.instr_rdata_i  = mem_data(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus.instr_rvalid_i = 1'b0;
      bus.instr_rdata_i  = $urandom;
    end
    #1;
    s_req    = bus.instr_req_o;
    s_addr   = bus.instr_addr_o;
    s_rvalid = bus.instr_rvalid_i;
    s_valid  = bus.out_valid_o;
    // Fetch only while enabled, not jumping, under the in-flight limit, and with a slot for every live fetch.
    exp_req = fetch_en_i && !fl && ((mem_q.size() + int'(s_rvalid)) < MAXO) && (exp_q.size() < DEPTH);
    check("instr_req", s_req, exp_req);
    if (s_req) check("instr_addr", s_addr, model_pc);
    if (s_valid && first_valid_step < 0) first_valid_step = step_n;
    if (s_req && bus.instr_gnt_i) begin
      r.addr = s_addr;
      r.due  = step_n + 1 + $urandom_range(dmin, dmax);
      mem_q.push_back(r);
      exp_q.push_back(s_addr);
      model_pc = model_pc + 32'd4;
      grants++;
      if (first_gnt_step < 0) first_gnt_step = step_n;
    end
    if (fl) begin
      exp_q.delete();
      popped_q.delete();
      model_pc = flush_addr_i & ~32'd3;
    end
  endtask

  // Monitor: every ID handshake must deliver the oldest live fetch, with its data.
  initial begin
    logic          hold_v;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    logic [AW-1:0] e;
    hold_v = 1'b0;
    hold_a = '0;
    hold_d = '0;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni) begin
        if (hold_v) begin
          check("hold_addr", bus.out_addr_o, hold_a);
          check("hold_rdata", bus.out_rdata_o, hold_d);
        end
        hold_v = bus.out_valid_o && !bus.out_ready_i && !flush_i;
        hold_a = bus.out_addr_o;
        hold_d = bus.out_rdata_o;
        if (bus.out_valid_o && bus.out_ready_i && !flush_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_pop: got addr %h, expected no live entry (step %0d)", bus.out_addr_o, step_n);
          end else begin
            e = exp_q.pop_front();
            check("out_addr", bus.out_addr_o, e);
            check("out_rdata", bus.out_rdata_o, mem_data(e));
          end
          popped_q.push_back(bus.out_addr_o);
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at step %0d", step_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int sim_rv;
    boot_addr_i        = 32'h8000_0000;
    fetch_en_i         = 1'b1;
    flush_i            = 1'b0;
    flush_addr_i       = '0;
    bus.instr_gnt_i    = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.instr_rdata_i  = '0;
    bus.out_ready_i    = 1'b1;
    force_flush = 1'b0;
    force_addr  = '0;
    gnt_pct = 100; ready_pct = 100; flush_pct = 0; fe_pct = 100; dmin = 0; dmax = 0;

    // Reset values
    repeat (3) @(negedge clk_i);
    check("rst_req", bus.instr_req_o, 1'b0);
    check("rst_addr", bus.instr_addr_o, 32'h0);
    check("rst_valid", bus.out_valid_o, 1'b0);
    check("rst_rdata", bus.out_rdata_o, 32'h0);
    check("rst_out_addr", bus.out_addr_o, 32'h0);

    // Boot: one quiet BOOT cycle, then sequential fetch from the boot address
    rst_ni = 1'b1;
    #1;
    check("boot_req_low", bus.instr_req_o, 1'b0);
    model_pc = 32'h8000_0000;
    step();
    check("boot_first_req", s_req, 1'b1);
    check("boot_first_addr", s_addr, 32'h8000_0000);
    repeat (8) step();
    check("boot_valid_latency", first_valid_step - first_gnt_step, 2);
    check("boot_pop0", pv(0), 32'h8000_0000);
    check("boot_pop1", pv(1), 32'h8000_0004);
    check("boot_pop2", pv(2), 32'h8000_0008);

    // Back-pressure: with ID stalled exactly DEPTH fetches are issued, then drained in order
    ready_pct = 0;
    force_flush = 1'b1; force_addr = 32'h0000_2000;
    step();
    g0 = grants;
    repeat (20) step();
    check("bp_grants", grants - g0, DEPTH);
    check("bp_req_low", s_req, 1'b0);
    check("bp_valid", s_valid, 1'b1);
    ready_pct = 100;
    repeat (12) step();
    check("bp_pop0", pv(0), 32'h0000_2000);
    check("bp_pop1", pv(1), 32'h0000_2004);
    check("bp_pop2", pv(2), 32'h0000_2008);
    check("bp_pop3", pv(3), 32'h0000_200C);
    check("bp_pop4", pv(4), 32'h0000_2010);

    // Jump with two fetches in flight: both stale responses must vanish
    dmin = 4; dmax = 4;
    repeat (6) step();
    force_flush = 1'b1; force_addr = 32'h0000_0100;
    step();
    dmin = 1; dmax = 1;
    repeat (14) step();
    check("flush_pop0", pv(0), 32'h0000_0100);
    check("flush_pop1", pv(1), 32'h0000_0104);

    // Jump coinciding with gnt, rvalid and ready
    dmin = 0; dmax = 0;
    repeat (6) step();
    force_flush = 1'b1; force_addr = 32'h0000_0300;
    step();
    sim_rv = int'(s_rvalid);
    check("sim_rvalid_present", sim_rv, 1);
    check("sim_req_low", s_req, 1'b0);
    step();
    check("sim_valid_after", s_valid, 1'b0);
    repeat (6) step();
    check("sim_pop0", pv(0), 32'h0000_0300);

    // Unaligned jump target near the top of the address space
    force_flush = 1'b1; force_addr = 32'hFFFF_FFFE;
    step();
    step();
    check("wrap_req", s_req, 1'b1);
    check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr1", s_addr, 32'h0000_0000);
    repeat (6) step();
    check("wrap_pop0", pv(0), 32'hFFFF_FFFC);
    check("wrap_pop1", pv(1), 32'h0000_0000);

    // Random traffic
    gnt_pct = 70; ready_pct = 70; flush_pct = 2; fe_pct = 90; dmin = 0; dmax = 5;
    repeat (10000) step();

    // Drain: stop fetching and let everything live reach ID
    gnt_pct = 100; ready_pct = 100; flush_pct = 0; fe_pct = 0;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || mem_q.size() != 0); i++) step();
    check("drain_live_left", exp_q.size(), 0);
    check("drain_mem_left", mem_q.size(), 0);
    step();
    check("drain_valid", s_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
